fns_cac_decoder_42: RTL and testbench

Iterative decoder for the 42-bit Fibonacci-numeral-system (FNS) crosstalk-avoidance codeword. It sits directly downstream of the 42-bit IDP encoder on the receive side of the bus. It takes a registered 42-bit codeword and reconstructs the `IBLEN42`-bit binary word. Words are accepted and delivered through valid/ready handshakes, and the weighted sum is accumulated over several cycles.

---
 rtl/fns_cac_pkg.sv | 44 ++++
 rtl/fns_msb_offset_lut.sv | 29 ++
 rtl/fns_cac_decoder_42.sv | 106 ++++++++++
 tb/tb_fns_cac_decoder_42.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fns_cac_pkg.sv
// Shared constants, FSM state type and Fibonacci digit weights for the FNS CAC decoders.
package fns_cac_pkg;

  localparam int CW_LEN42  = 42;
  localparam int DIG_LEN42 = 38;
  localparam int IBLEN42   = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } dec_state_e;

  typedef logic [IBLEN42-1:0]                  fns_word_t;
  typedef logic [DIG_LEN42-1:0][IBLEN42-1:0]   dig_wtab_t;

  // FNS(1) = FNS(2) = 1, FNS(n) = FNS(n-1) + FNS(n-2)
  function automatic fns_word_t fns(input int n);
    fns_word_t a, b, t;
    a = fns_word_t'(1);
    b = fns_word_t'(1);
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic dig_wtab_t build_dig_w();
    dig_wtab_t w;
    w[0] = fns_word_t'(1);
    for (int k = 1; k < DIG_LEN42; k++) begin
      w[k] = fns(k + 1);
    end
    return w;
  endfunction

  localparam dig_wtab_t DIG_W = build_dig_w();
  localparam fns_word_t FNS39 = fns(39);
  localparam fns_word_t FNS41 = fns(41);
  localparam fns_word_t FNS42 = fns(42);

endpackage

// File: rtl/fns_msb_offset_lut.sv
// Combinational MSB-nibble offset table; zero latency, no handshake.
// Unlisted nibbles return offset 0 with o_nibble_ok low.
module fns_msb_offset_lut
  import fns_cac_pkg::*;
(
  input  logic [3:0] i_nibble,
  output fns_word_t  o_offset,
  output logic       o_nibble_ok
);

  always_comb begin
    o_offset    = '0;
    o_nibble_ok = 1'b1;
    case (i_nibble)
      4'b0000: o_offset = '0;
      4'b0001: o_offset = FNS39;
      4'b1000: o_offset = FNS41;
      4'b1001: o_offset = FNS39 + FNS41;
      4'b0011: o_offset = FNS39 + FNS42;
      4'b1100: o_offset = FNS41 + FNS42;
      4'b0110: o_offset = FNS42 + FNS42;
      4'b0111: o_offset = FNS42 + FNS42 + FNS39;
      4'b1110: o_offset = FNS42 + FNS42 + FNS41;
      4'b1111: o_offset = FNS42 + FNS42 + FNS41 + FNS39;
      default: o_nibble_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/fns_cac_decoder_42.sv
// Iterative 42-bit FNS codeword decoder: ceil(38/LANES) cycles per word, output held until out_ready.
// Define FNS_DEC_ERRCHK_EN to flag invalid MSB nibbles on err; otherwise err is tied low.
module fns_cac_decoder_42
  import fns_cac_pkg::*;
#(
  parameter int LANES = 8
)(
  input  logic                clock,
  input  logic                rst_n,
  input  logic [CW_LEN42-1:0] code_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IBLEN42-1:0]  data_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err
);

  localparam int               ITER  = (DIG_LEN42 + LANES - 1) / LANES;
  localparam int               CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

  dec_state_e           r_state, w_state_nxt;
  logic [DIG_LEN42-1:0] r_dig;
  fns_word_t            r_acc, w_chunk_sum, w_offset;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_nib_ok, w_take, w_last;
  int                   w_pos;
  logic [5:0]           w_sel;

  fns_msb_offset_lut u_msb_lut (
    .i_nibble    (code_in[CW_LEN42-1:DIG_LEN42]),
    .o_offset    (w_offset),
    .o_nibble_ok (w_nib_ok)
  );

  assign in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_take    = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST);
  assign out_valid = (r_state == HOLD);
  assign data_out  = r_acc;

  // Chunk r_cnt spans digits 37-LANES*r_cnt downward; positions below bit 0 are zero lanes.
  always_comb begin
    w_chunk_sum = '0;
    w_pos       = 0;
    w_sel       = '0;
    for (int j = 0; j < LANES; j++) begin
      w_pos = DIG_LEN42 - 1 - LANES * int'(r_cnt) - j;
      w_sel = 6'(w_pos);
      if ((w_pos >= 0) && r_dig[w_sel]) begin
        w_chunk_sum = w_chunk_sum + DIG_W[w_sel];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = ACC;
      ACC:     if (w_last) w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = in_valid ? ACC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dig   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_dig <= code_in[DIG_LEN42-1:0];
        r_acc <= w_offset;
        r_cnt <= '0;
      end else if (r_state == ACC) begin
        r_acc <= r_acc + w_chunk_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef FNS_DEC_ERRCHK_EN
  logic r_nib_bad, r_err;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_nib_bad <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_take) r_nib_bad <= !w_nib_ok;
      if ((r_state == ACC) && w_last) r_err <= r_nib_bad;
    end
  end

  assign err = r_err;
`else
  logic w_nib_ok_unused;
  assign w_nib_ok_unused = w_nib_ok;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fns_cac_decoder_42.sv
// Bench for fns_cac_decoder_42 at LANES = 1, 8, 38 against a Fibonacci-sum reference model.
module tb_fns_cac_decoder_42;

`ifdef FNS_DEC_ERRCHK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  localparam int ITERS [3] = '{38, 5, 1};
  localparam logic [3:0] OK_NIB [10] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h3, 4'hC, 4'h6, 4'h7, 4'hE, 4'hF};

  logic        clock = 1'b0;
  logic        rst_n;
  logic [41:0] code_in   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [29:0] data_out  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        err       [3];

  int nvec  = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  fns_cac_decoder_42 #(.LANES(1)) u_dut_l1 (
    .clock(clock), .rst_n(rst_n), .code_in(code_in[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_out(data_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .err(err[0]));
  fns_cac_decoder_42 #(.LANES(8)) u_dut_l8 (
    .clock(clock), .rst_n(rst_n), .code_in(code_in[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_out(data_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .err(err[1]));
  fns_cac_decoder_42 #(.LANES(38)) u_dut_l38 (
    .clock(clock), .rst_n(rst_n), .code_in(code_in[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_out(data_out[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .err(err[2]));

  // ---------------- reference model ----------------
  function automatic longint fib(input int n);
    longint a, b, t;
    a = 1;
    b = 1;
    for (int k = 3; k <= n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic longint model_val(input logic [41:0] cw);
    longint s;
    s = cw[0] ? 1 : 0;
    for (int k = 1; k < 38; k++) if (cw[k]) s += fib(k + 1);
    case (cw[41:38])
      4'b0001: s += fib(39);
      4'b1000: s += fib(41);
      4'b1001: s += fib(39) + fib(41);
      4'b0011: s += fib(39) + fib(42);
      4'b1100: s += fib(41) + fib(42);
      4'b0110: s += 2 * fib(42);
      4'b0111: s += 2 * fib(42) + fib(39);
      4'b1110: s += 2 * fib(42) + fib(41);
      4'b1111: s += 2 * fib(42) + fib(41) + fib(39);
      default: s += 0;
    endcase
    return s;
  endfunction

  function automatic bit model_err(input logic [41:0] cw);
    return ERR_ON && !(cw[41:38] inside {4'h0, 4'h1, 4'h8, 4'h9, 4'h3, 4'hC, 4'h6, 4'h7, 4'hE, 4'hF});
  endfunction

  // One word at most in flight per decoder: pend marks it, pedge is its handshake edge.
  int     ecnt = 0;
  bit     pend  [3];
  longint pval  [3];
  bit     perr  [3];
  int     pedge [3];

  function automatic bit exp_ov(input int i);
    return pend[i] && (ecnt >= pedge[i] + ITERS[i]);
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pend[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (exp_ov(i) && out_ready[i]) pend[i] <= 1'b0;
        if (in_valid[i] && (!pend[i] || (exp_ov(i) && out_ready[i]))) begin
          pend[i]  <= 1'b1;
          pval[i]  <= model_val(code_in[i]);
          perr[i]  <= model_err(code_in[i]);
          pedge[i] <= ecnt + 1;
        end
      end
      ecnt <= ecnt + 1;
    end
  end

  task automatic check(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s (inst %0d): got %0d, expected %0d", nm, inst, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check("m_out_valid", i, 64'(out_valid[i]), 64'(exp_ov(i)));
        check("m_in_ready", i, 64'(in_ready[i]), 64'(!pend[i] || (exp_ov(i) && out_ready[i])));
        if (exp_ov(i)) begin
          check("m_data_out", i, 64'(data_out[i]), 64'(pval[i]));
          check("m_err", i, 64'(err[i]), 64'(perr[i]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic put_word(input int i, input logic [41:0] cw);
    bit ok;
    ok = 1'b0;
    code_in[i]  = cw;
    in_valid[i] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (in_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    in_valid[i] = 1'b0;
    code_in[i]  = {10'($urandom), $urandom};
    if (!ok) begin
      nvec++; nfail++;
      $display("FAIL in_ready_timeout (inst %0d): got 0, expected 1", i);
    end
  endtask

  task automatic wait_ov(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid[i]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      nvec++; nfail++;
      $display("FAIL out_valid_timeout (inst %0d): got 0, expected 1", i);
    end
  endtask

  task automatic get_word(input int i, input int hold);
    bit ok;
    wait_ov(i, ok);
    repeat (hold) begin @(posedge clock); #1; end
    out_ready[i] = 1'b1;
    @(posedge clock); #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic xact(input int i, input logic [41:0] cw, input longint exp_d, input bit exp_e, input string nm);
    bit ok;
    put_word(i, cw);
    wait_ov(i, ok);
    if (ok) begin
      check({nm, "_data"}, i, 64'(data_out[i]), 64'(exp_d));
      check({nm, "_err"}, i, 64'(err[i]), 64'(exp_e));
    end
    out_ready[i] = 1'b1;
    @(posedge clock); #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic directed(input int i);
    xact(i, 42'h00000000000, 0,         1'b0,   "zero");
    xact(i, 42'h00000000001, 1,         1'b0,   "bit0");
    xact(i, 42'h00000000002, 1,         1'b0,   "bit1");
    xact(i, 42'h00000000004, 2,         1'b0,   "bit2");
    xact(i, 42'h00000000020, 8,         1'b0,   "bit5");
    xact(i, 42'h00020000000, 832040,    1'b0,   "bit29");
    xact(i, 42'h02000000000, 39088169,  1'b0,   "bit37");
    xact(i, 42'h3C000000000, 764654719, 1'b0,   "nib1111");
    xact(i, 42'h04000000000, 63245986,  1'b0,   "nib0001");
    xact(i, 42'h08000000000, 0,         ERR_ON, "nib0010");
    xact(i, 42'h1A000000001, 574916762, 1'b0,   "mixed");
  endtask

  function automatic logic [41:0] rand_cw();
    logic [3:0] nib;
    if ($urandom_range(0, 3) == 0) nib = 4'($urandom_range(0, 15));
    else                           nib = OK_NIB[$urandom_range(0, 9)];
    return {nib, 6'($urandom), $urandom};
  endfunction

  task automatic run_words(input int i, input int n);
    fork
      begin
        for (int w = 0; w < n; w++) put_word(i, rand_cw());
      end
      begin
        for (int w = 0; w < n; w++) get_word(i, int'($urandom_range(0, 2)));
      end
    join
  endtask

  // ---------------- sequence ----------------
  initial begin
    bit ok;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      code_in[i]   = '0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", i, 64'(out_valid[i]), 64'd0);
      check("rst_in_ready",  i, 64'(in_ready[i]),  64'd1);
      check("rst_data_out",  i, 64'(data_out[i]),  64'd0);
      check("rst_err",       i, 64'(err[i]),       64'd0);
    end
    rst_n = 1'b1;
    @(posedge clock); #1;

    check("model_pin_mixed", 1, 64'(model_val(42'h1A000000001)), 64'd574916762);
    check("model_pin_bit37", 1, 64'(model_val(42'h02000000000)), 64'd39088169);

    for (int i = 0; i < 3; i++) directed(i);

    // Backpressure for 10 cycles, then release with the next word already offered.
    put_word(1, 42'h02000000000);
    wait_ov(1, ok);
    code_in[1]  = 42'h00000000001;
    in_valid[1] = 1'b1;
    repeat (10) begin
      check("hold_data",     1, 64'(data_out[1]),  64'd39088169);
      check("hold_valid",    1, 64'(out_valid[1]), 64'd1);
      check("hold_in_ready", 1, 64'(in_ready[1]),  64'd0);
      @(posedge clock); #1;
    end
    out_ready[1] = 1'b1;
    #3;
    check("release_in_ready", 1, 64'(in_ready[1]), 64'd1);
    @(posedge clock); #1;
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b0;
    code_in[1]   = 42'h3FFFFFFFFFF;
    check("b2b_valid_drop", 1, 64'(out_valid[1]), 64'd0);
    check("b2b_busy",       1, 64'(in_ready[1]),  64'd0);
    wait_ov(1, ok);
    if (ok) check("b2b_data", 1, 64'(data_out[1]), 64'd1);
    out_ready[1] = 1'b1;
    @(posedge clock); #1;
    out_ready[1] = 1'b0;

    // Reset in the middle of accumulation drops the word.
    put_word(1, 42'h3C000000000);
    @(posedge clock); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",    1, 64'(out_valid[1]), 64'd0);
    check("rst_mid_in_ready", 1, 64'(in_ready[1]),  64'd1);
    @(posedge clock); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clock); #1;
      check("post_rst_valid", 1, 64'(out_valid[1]), 64'd0);
    end

    fork
      run_words(0, 1000);
      run_words(1, 1000);
      run_words(2, 1000);
    join

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
